// File: rtl/rv_instr_encoder_if.sv
// rv_instr_encoder_if
//   Request/response stream bundle for the RV64I instruction encoder.
//   Request side : in_valid/in_ready handshake plus op, register numbers,
//                  immediate/target and pc of the first emitted word.
//   Response side: out_valid/out_ready handshake plus encoded word, its pc,
//                  error flag and last-word-of-request flag.
//   master: stimulus sequencer (drives requests, consumes words)
//   slave : encoder
interface rv_instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [63:0] in_imm;
   logic [63:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        out_err;
   logic        out_last;

   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_err, out_last
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_err, out_last
   );
endinterface

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder
//   RV64I instruction encoder (inverse of the decoder). Takes an op code with
//   symbolic operands, range-checks immediates and branch/jump targets,
//   expands the li pseudo-instruction into one or two words and emits 32-bit
//   machine words on a valid/ready stream. Illegal requests produce a single
//   all-zero word flagged with out_err.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high reset
//   bus   - rv_instr_encoder_if.slave (request and response streams)
module rv_instr_encoder (
   input logic              clk,
   input logic              reset,
   rv_instr_encoder_if.slave bus
);

   typedef enum logic [1:0] {EMPTY, HOLD, HOLD_PEND} state_t;

   typedef enum logic [4:0] {
      OP_LUI   = 5'd0,  OP_AUIPC = 5'd1,  OP_JAL   = 5'd2,  OP_JALR  = 5'd3,
      OP_BEQ   = 5'd4,  OP_BNE   = 5'd5,  OP_BLT   = 5'd6,  OP_BGE   = 5'd7,
      OP_BLTU  = 5'd8,  OP_BGEU  = 5'd9,
      OP_LB    = 5'd10, OP_LH    = 5'd11, OP_LW    = 5'd12, OP_LD    = 5'd13,
      OP_LBU   = 5'd14, OP_LHU   = 5'd15, OP_LWU   = 5'd16,
      OP_SB    = 5'd17, OP_SH    = 5'd18, OP_SW    = 5'd19, OP_SD    = 5'd20,
      OP_ADDI  = 5'd21, OP_SLLI  = 5'd22, OP_SRLI  = 5'd23, OP_SRAI  = 5'd24,
      OP_ADD   = 5'd25, OP_SUB   = 5'd26, OP_ADDIW = 5'd27, OP_ADDW  = 5'd28,
      OP_SUBW  = 5'd29, OP_LI    = 5'd30, OP_RSVD  = 5'd31
   } op_t;

   // ---------------------------------------------------------------- formats
   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
      return {f7, rs2, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
      return {imm, rd, opc};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction

   // ------------------------------------------------------------ range checks
   logic [63:0] imm;
   logic [63:0] offset;
   logic        imm_s12;
   logic        imm_s32;
   logic        imm_u20;
   logic        imm_sh6;
   logic        off_j_ok;
   logic        off_b_ok;
   logic [19:0] li_hi;
   logic [11:0] li_lo;

   assign imm    = bus.in_imm;
   assign offset = bus.in_imm - bus.in_pc;

   // A value fits N signed bits when everything above bit N-1 is a copy of it.
   assign imm_s12  = (&imm[63:11]) | ~(|imm[63:11]);
   assign imm_s32  = (&imm[63:31]) | ~(|imm[63:31]);
   assign imm_u20  = ~(|imm[63:20]);
   assign imm_sh6  = ~(|imm[63:6]);
   assign off_j_ok = ((&offset[63:20]) | ~(|offset[63:20])) && (offset[1:0] == 2'b00);
   assign off_b_ok = ((&offset[63:12]) | ~(|offset[63:12])) && (offset[1:0] == 2'b00);

   // (imm + 0x800) >> 12 rounds the upper part so that the sign-extended low
   // 12 bits added by addiw land on the original value.
   assign li_hi = imm[31:12] + {19'b0, imm[11]};
   assign li_lo = imm[11:0];

   // ----------------------------------------------------------- funct3 table
   logic [2:0] f3;

   always_comb begin
      f3 = 3'd0;
      case (op_t'(bus.in_op))
         OP_BNE:  f3 = 3'd1;
         OP_BLT:  f3 = 3'd4;
         OP_BGE:  f3 = 3'd5;
         OP_BLTU: f3 = 3'd6;
         OP_BGEU: f3 = 3'd7;
         OP_LH:   f3 = 3'd1;
         OP_LW:   f3 = 3'd2;
         OP_LD:   f3 = 3'd3;
         OP_LBU:  f3 = 3'd4;
         OP_LHU:  f3 = 3'd5;
         OP_LWU:  f3 = 3'd6;
         OP_SH:   f3 = 3'd1;
         OP_SW:   f3 = 3'd2;
         OP_SD:   f3 = 3'd3;
         OP_SLLI: f3 = 3'd1;
         OP_SRLI: f3 = 3'd5;
         OP_SRAI: f3 = 3'd5;
         default: f3 = 3'd0;
      endcase
   end

   // --------------------------------------------------------------- encoder
   logic [31:0] word1;
   logic [31:0] word2;
   logic        enc_err;
   logic        two_word;

   always_comb begin
      word1    = '0;
      word2    = '0;
      enc_err  = 1'b0;
      two_word = 1'b0;
      case (op_t'(bus.in_op))
         OP_LUI: begin
            enc_err = !imm_u20;
            word1   = enc_u(imm[19:0], bus.in_rd, 7'h37);
         end
         OP_AUIPC: begin
            enc_err = !imm_u20;
            word1   = enc_u(imm[19:0], bus.in_rd, 7'h17);
         end
         OP_JAL: begin
            enc_err = !off_j_ok;
            word1   = enc_j(offset[20:1], bus.in_rd);
         end
         OP_JALR: begin
            enc_err = !imm_s12;
            word1   = enc_i(imm[11:0], bus.in_rs1, 3'd0, bus.in_rd, 7'h67);
         end
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            enc_err = !off_b_ok;
            word1   = enc_b(offset[12:1], bus.in_rs2, bus.in_rs1, f3);
         end
         OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU: begin
            enc_err = !imm_s12;
            word1   = enc_i(imm[11:0], bus.in_rs1, f3, bus.in_rd, 7'h03);
         end
         OP_SB, OP_SH, OP_SW, OP_SD: begin
            enc_err = !imm_s12;
            word1   = enc_s(imm[11:0], bus.in_rs2, bus.in_rs1, f3);
         end
         OP_ADDI: begin
            enc_err = !imm_s12;
            word1   = enc_i(imm[11:0], bus.in_rs1, 3'd0, bus.in_rd, 7'h13);
         end
         OP_ADDIW: begin
            enc_err = !imm_s12;
            word1   = enc_i(imm[11:0], bus.in_rs1, 3'd0, bus.in_rd, 7'h1B);
         end
         OP_SLLI, OP_SRLI, OP_SRAI: begin
            enc_err = !imm_sh6;
            word1   = enc_i({(bus.in_op == OP_SRAI) ? 6'b010000 : 6'b000000, imm[5:0]},
                            bus.in_rs1, f3, bus.in_rd, 7'h13);
         end
         OP_ADD, OP_SUB: begin
            word1 = enc_r((bus.in_op == OP_SUB) ? 7'h20 : 7'h00, bus.in_rs2, bus.in_rs1,
                          3'd0, bus.in_rd, 7'h33);
         end
         OP_ADDW, OP_SUBW: begin
            word1 = enc_r((bus.in_op == OP_SUBW) ? 7'h20 : 7'h00, bus.in_rs2, bus.in_rs1,
                          3'd0, bus.in_rd, 7'h3B);
         end
         OP_LI: begin
            if (imm_s12) begin
               word1 = enc_i(imm[11:0], 5'd0, 3'd0, bus.in_rd, 7'h13);
            end else if (imm_s32) begin
               word1    = enc_u(li_hi, bus.in_rd, 7'h37);
               word2    = enc_i(li_lo, bus.in_rd, 3'd0, bus.in_rd, 7'h1B);
               two_word = (li_lo != 12'd0);
            end else begin
               enc_err = 1'b1;
            end
         end
         default: enc_err = 1'b1;
      endcase
      if (enc_err) begin
         word1    = '0;
         two_word = 1'b0;
      end
   end

   // ------------------------------------------------------- output stage FSM
   state_t      state;
   logic        out_valid_q;
   logic [31:0] out_instr_q;
   logic [63:0] out_pc_q;
   logic        out_err_q;
   logic        out_last_q;
   logic [31:0] pend_instr;
   logic [63:0] pend_pc;
   logic        in_ready_c;
   logic        accept;

   assign in_ready_c = (state != HOLD_PEND) && (!out_valid_q || bus.out_ready);
   assign accept     = bus.in_valid && in_ready_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
         out_err_q   <= 1'b0;
         out_last_q  <= 1'b0;
         pend_instr  <= '0;
         pend_pc     <= '0;
      end else begin
         case (state)
            EMPTY, HOLD: begin
               if (accept) begin
                  out_valid_q <= 1'b1;
                  out_instr_q <= word1;
                  out_pc_q    <= bus.in_pc;
                  out_err_q   <= enc_err;
                  out_last_q  <= !two_word;
                  pend_instr  <= word2;
                  pend_pc     <= bus.in_pc + 64'd4;
                  state       <= two_word ? HOLD_PEND : HOLD;
               end else if (state == HOLD && bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= EMPTY;
               end
            end
            HOLD_PEND: begin
               if (bus.out_ready) begin
                  out_instr_q <= pend_instr;
                  out_pc_q    <= pend_pc;
                  out_err_q   <= 1'b0;
                  out_last_q  <= 1'b1;
                  state       <= HOLD;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state       <= EMPTY;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_instr = out_instr_q;
   assign bus.out_pc    = out_pc_q;
   assign bus.out_err   = out_err_q;
   assign bus.out_last  = out_last_q;

endmodule

// File: doc/rv_instr_encoder.md
# rv_instr_encoder

Pipelined RV64I instruction encoder, the inverse of the instruction decoder. It accepts an operation code with symbolic operands and emits 32-bit machine words through a valid/ready stream. It range-checks immediates and branch targets, and expands the `li` pseudo-instruction into one or two words. It sits between the test-program generator / stimulus sequencer and the instruction memory loader.

## Interface
Parameters:
- none (RV64I, no compressed extension; instruction alignment is 4 bytes)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  request valid
- `in_ready`  out  1  request accepted when `in_valid && in_ready`
- `in_op`  in  5  operation code:
  - 0 lui, 1 auipc, 2 jal, 3 jalr
  - 4–9 beq/bne/blt/bge/bltu/bgeu
  - 10–16 lb/lh/lw/ld/lbu/lhu/lwu
  - 17–20 sb/sh/sw/sd
  - 21 addi, 22 slli, 23 srli, 24 srai, 25 add, 26 sub, 27 addiw, 28 addw, 29 subw
  - 30 li
  - 31 reserved
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register numbers; unused fields are ignored
- `in_imm`  in  64  signed operand, interpreted per op (see Operation)
- `in_pc`  in  64  address of the first emitted word
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  consumer accepts the word
- `out_instr`  out  32  encoded word
- `out_pc`  out  64  address of `out_instr`
- `out_err`  out  1  request was illegal; `out_instr` = 0x00000000
- `out_last`  out  1  final word of the current request

## Operation
Immediate interpretation per op class:
- lui/auipc: `in_imm` is the 20-bit upper field. Legal range 0..0xFFFFF.
- jal, branches: `in_imm` is the absolute target address.
  - offset = target − `in_pc`, computed in 64 bits.
  - Error if offset[1:0] ≠ 0.
  - jal legal offset range: −2^20..2^20−4. Branch legal range: −4096..4092.
- jalr, loads, stores, addi, addiw: `in_imm` is a signed 12-bit value, range −2048..2047.
- slli/srli/srai: shamt range 0..63; encoded in bits [25:20], with funct6 = 0b010000 for srai.
- add/sub/addw/subw: `in_imm` is ignored. sub and subw use funct7 = 0x20.
- Field packing follows the standard R/I/S/B/U/J formats, with the standard opcodes and funct3 values.

`li` expansion:
- If `in_imm` fits signed 12 bits: one word, `addi rd,x0,imm`.
- Else if it fits signed 32 bits:
  - lo = sign-extended `imm[11:0]`; hi = `(imm + 0x800) >> 12`, bits [19:0].
  - Emit `lui rd,hi`.
  - If lo ≠ 0, then emit `addiw rd,rd,lo` at `pc+4`. If lo = 0, `lui` is the only word.
- Otherwise: error.

Errors:
- Triggered by any out-of-range value, a misaligned target, or op 31.
- Response is exactly one word with `out_instr` = 0, `out_err` = 1, `out_last` = 1.

FSM:
- States are EMPTY, HOLD and HOLD_PEND.
- EMPTY: `out_valid` = 0.
- HOLD: one word is registered.
- HOLD_PEND: a word is registered and the second `li` word is queued internally.
- Transitions:
  - EMPTY→HOLD on accept.
  - HOLD→EMPTY on `out_ready` with no new accept.
  - HOLD→HOLD on `out_ready` with a simultaneous accept.
  - Accept of a two-word `li` → HOLD_PEND.
  - HOLD_PEND→HOLD on `out_ready`: the second word is loaded, with `out_last` = 1.
- `in_ready` = (state ≠ HOLD_PEND) && (!`out_valid` || `out_ready`). This is combinational from state and `out_ready`.
- Output registers hold stable while `out_valid && !out_ready`.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = EMPTY
  - `out_valid` = 0, `out_instr` = 0, `out_pc` = 0, `out_err` = 0, `out_last` = 0
  - `in_ready` follows the formula (1 after reset).
- Latency: the word appears with `out_valid` = 1 in the cycle after accept.
- Throughput: one word per cycle when `out_ready` is held at 1.
  - A two-word `li` blocks `in_ready` for one cycle, so 2 words are emitted per 2 cycles.
- Reset asserted mid-`li` (in HOLD_PEND) discards the pending second word. No partial word appears after reset.

## Test plan
- addi, a0=x10, rs1=0, imm=5 → `out_instr` = 0x00500513, `out_last` = 1, `out_err` = 0, one cycle after accept.
- li, rd=10, imm=0x12345678:
  - First word 0x12345537 (`out_last` = 0), then 0x6785051B at `out_pc` = `in_pc`+4 (`out_last` = 1).
  - `in_ready` = 0 during the first word.
- li, rd=10, imm=0x12345000 → single word 0x12345537 with `out_last` = 1.
- jal, rd=1, `in_pc` = 0x1000, target 0x1010 → 0x010000EF.
  - beq with target 0x1002 → `out_err` = 1, instr 0.
  - bne with target `pc`+4096 → `out_err` = 1.
- sd, rs2=8, rs1=2, imm=8 → 0x00813423.
  - Hold `out_ready` = 0 for 3 cycles: outputs stay stable and `in_ready` = 0.
  - Then release: the next request is accepted in the same cycle.
- Assert `reset` while in HOLD_PEND → `out_valid` drops immediately and no `addiw` word is emitted afterwards.
